control_sequencer: RTL
======================

Name: control_sequencer

Overview:
Multi-cycle control unit that drives every control input of the CPU datapath. It decodes IR opcode bits [31:27], steps through fetch/execute T-states and samples CONFF for branches. It sits directly upstream of the datapath: its outputs wire one-to-one onto the datapath's control pins, and IR and CONFF feed back from the datapath.

Parameters:
OPW, 5, opcode width (IR[31:27])
STW, 5, state register width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low
IR  input  32  instruction register contents from the datapath
CONFF  input  1  branch-condition flip-flop from the datapath
stop  input  1  request halt at the next instruction boundary
clear  output  1  synchronous clear to the datapath registers
Run  output  1  high while executing; low in CLR and HALT
PCout, PCin, IncPC, MARin, MDRin, MDRout, MD_read, IRin  output  1 each  fetch/memory path controls
Read, Write  output  1 each  RAM strobes
Gra, Grb, Grc, Rin, Rout, BAout, Csignout  output  1 each  register-select and immediate controls
Yin, Zlowin, Zhighin, Zlowout, ADD, AND, OR, BRANCH, CONin  output  1 each  ALU and condition controls
HIout, LOout, InPortout, Out_Portin  output  1 each  special-register and I/O controls

Behaviour:
- Moore FSM. Outputs are decoded combinationally from the state register only; the single exception is PCin in BR_T7, which also depends on CONFF. All outputs not listed for a state are 0.
- While reset is low, state is CLR and all outputs are 0. In CLR, clear=1 and Run=0 for exactly one cycle; the FSM then moves to T0.
- Fetch sequence, common to all instructions:
  - T0: PCout, MARin, IncPC, Zlowin
  - T1: Zlowout, PCin, Read
  - T2: Read, MD_read, MDRin
  - T3: MDRout, IRin
  - T4 branches on IR[31:27] as registered by the end of T3.
- Opcodes: ld=00000, ldi=00001, st=00010, add=00011, and=00101, or=00110, addi=01100, andi=01101, ori=01110, br=10010, jr=10011, in=10101, out=10110, mfhi=10111, mflo=11000, nop=11001, halt=11010.
- R-type (add/and/or), with OP being the matching ADD/AND/OR line:
  - T4: Grb, Rout, Yin
  - T5: Grc, Rout, OP, Zlowin
  - T6: Zlowout, Gra, Rin
- I-type (addi/andi/ori): same as R-type, but T5 uses Csignout instead of Grc+Rout.
- Address phase (ld/ldi/st):
  - T4: Grb, BAout, Yin
  - T5: Csignout, ADD, Zlowin
- ldi T6: Zlowout, Gra, Rin.
- ld:
  - T6: Zlowout, MARin
  - T7: Read
  - T8: Read, MD_read, MDRin
  - T9: MDRout, Gra, Rin
- st:
  - T6: Zlowout, MARin
  - T7: Gra, Rout, Write
- br:
  - T4: Gra, Rout, CONin
  - T5: PCout, Yin
  - T6: Csignout, ADD, Zlowin
  - BR_T7: Zlowout, BRANCH; PCin=CONFF
- Single-cycle T4 instructions:
  - jr: Gra, Rout, PCin
  - in: InPortout, Gra, Rin
  - out: Gra, Rout, Out_Portin
  - mfhi: HIout, Gra, Rin
  - mflo: LOout, Gra, Rin
- nop and undefined opcodes: T4 asserts nothing.
- Every instruction's last state returns to T0.
- halt: T4 goes to HALT. HALT is absorbing with Run=0 and all controls 0; only reset exits it.
- stop: sampled in the last state of each instruction. If high, the next state is HALT instead of T0. A stop pulse mid-instruction is latched into a pending flag, so the current instruction always completes.
- Zhighin is never asserted by this opcode set; the port is kept for future mul/div.
- Reset asserted mid-instruction: the FSM goes to CLR immediately (asynchronous), outputs go to 0 immediately, and the pending-stop flag clears.
- Cycle counts, including fetch:
  - 5 cycles: nop, jr, in, out, mfhi, mflo
  - 7 cycles: R-type, I-type, ldi
  - 8 cycles: st, br
  - 10 cycles: ld

Decomposition:
- Shared package cpu_pkg holds the opcode constants (OP_LD … OP_HALT) and the state enumeration (CLR, T0–T3, per-instruction states, HALT), so the datapath bench can reuse them.
- One sub-module, ctrl_decode: a purely combinational state-to-control-word decoder. The top holds the state register, next-state logic and the stop latch.

Test Plan:
1. Release reset → clear=1 for one cycle, then T0 asserts PCout+MARin+IncPC+Zlowin; Run=1 from T0 on.
2. IR=add r1,r2,r3 (IR[31:27]=00011) → T4 Grb+Rout+Yin, T5 Grc+Rout+ADD+Zlowin, T6 Gra+Rin, then T0; 7 cycles total.
3. br with CONFF=0, then with CONFF=1 → BR_T7 shows PCin=0, then PCin=1; BRANCH=1 in both cases.
4. ld (00000) → Read high in T7 and T8; MD_read+MDRin in T8; MDRout+Gra+Rin in T9; 10 cycles total.
5. Pulse stop during T5 of an addi → instruction completes T6, then HALT with Run=0; stays there 20+ cycles.
6. Drive reset low during ld T8 → all outputs 0 immediately; after release, CLR then a T0 fetch.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, sequencer state encoding and the
// control word that the sequencer drives onto the datapath.
package cpu_pkg;

  localparam int OP_W = 5;
  localparam int ST_W = 5;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10010;
  localparam logic [OP_W-1:0] OP_JR   = 5'b10011;
  localparam logic [OP_W-1:0] OP_IN   = 5'b10101;
  localparam logic [OP_W-1:0] OP_OUT  = 5'b10110;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b10111;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11001;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

  // T4 is shared by all opcodes; per-instruction states start at T5.
  typedef enum logic [ST_W-1:0] {
    CLR, T0, T1, T2, T3, T4,
    ADD_T5, AND_T5, OR_T5, ADDI_T5, ANDI_T5, ORI_T5, ALU_T6,
    LD_T5, LDI_T5, ST_T5, LD_T6, LD_T7, LD_T8, LD_T9, ST_T6, ST_T7,
    BR_T5, BR_T6, BR_T7, HALT
  } state_e;

  typedef struct packed {
    logic clear, run;
    logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, md_read, ir_in;
    logic read, write;
    logic gra, grb, grc, r_in, r_out, ba_out, csign_out;
    logic y_in, zlow_in, zhigh_in, zlow_out, alu_add, alu_and, alu_or, branch, con_in;
    logic hi_out, lo_out, inport_out, outport_in;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational state-to-control-word decoder. T4 also looks at the opcode,
// because IR only becomes valid at the edge that enters T4.
module ctrl_decode
  import cpu_pkg::*;
(
  input  state_e          state_i,
  input  logic [OP_W-1:0] opcode_i,
  input  logic            conff_i,
  output ctrl_t           ctrl_o
);

  always_comb begin
    ctrl_o     = '0;
    ctrl_o.run = (state_i != CLR) && (state_i != HALT);
    case (state_i)
      CLR: ctrl_o.clear = 1'b1;
      T0:  begin ctrl_o.pc_out = 1'b1; ctrl_o.mar_in = 1'b1; ctrl_o.inc_pc = 1'b1; ctrl_o.zlow_in = 1'b1; end
      T1:  begin ctrl_o.zlow_out = 1'b1; ctrl_o.pc_in = 1'b1; ctrl_o.read = 1'b1; end
      T2:  begin ctrl_o.read = 1'b1; ctrl_o.md_read = 1'b1; ctrl_o.mdr_in = 1'b1; end
      T3:  begin ctrl_o.mdr_out = 1'b1; ctrl_o.ir_in = 1'b1; end
      T4: begin
        case (opcode_i)
          OP_ADD, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI:
                   begin ctrl_o.grb = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.y_in = 1'b1; end
          OP_LD, OP_LDI, OP_ST:
                   begin ctrl_o.grb = 1'b1; ctrl_o.ba_out = 1'b1; ctrl_o.y_in = 1'b1; end
          OP_BR:   begin ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.con_in = 1'b1; end
          OP_JR:   begin ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.pc_in = 1'b1; end
          OP_IN:   begin ctrl_o.inport_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1; end
          OP_OUT:  begin ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.outport_in = 1'b1; end
          OP_MFHI: begin ctrl_o.hi_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1; end
          OP_MFLO: begin ctrl_o.lo_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1; end
          default: ;
        endcase
      end
      ADD_T5:  begin ctrl_o.grc = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.alu_add = 1'b1; ctrl_o.zlow_in = 1'b1; end
      AND_T5:  begin ctrl_o.grc = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.alu_and = 1'b1; ctrl_o.zlow_in = 1'b1; end
      OR_T5:   begin ctrl_o.grc = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.alu_or = 1'b1; ctrl_o.zlow_in = 1'b1; end
      ADDI_T5: begin ctrl_o.csign_out = 1'b1; ctrl_o.alu_add = 1'b1; ctrl_o.zlow_in = 1'b1; end
      ANDI_T5: begin ctrl_o.csign_out = 1'b1; ctrl_o.alu_and = 1'b1; ctrl_o.zlow_in = 1'b1; end
      ORI_T5:  begin ctrl_o.csign_out = 1'b1; ctrl_o.alu_or = 1'b1; ctrl_o.zlow_in = 1'b1; end
      LD_T5, LDI_T5, ST_T5, BR_T6:
               begin ctrl_o.csign_out = 1'b1; ctrl_o.alu_add = 1'b1; ctrl_o.zlow_in = 1'b1; end
      ALU_T6:  begin ctrl_o.zlow_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1; end
      LD_T6, ST_T6:
               begin ctrl_o.zlow_out = 1'b1; ctrl_o.mar_in = 1'b1; end
      LD_T7:   ctrl_o.read = 1'b1;
      LD_T8:   begin ctrl_o.read = 1'b1; ctrl_o.md_read = 1'b1; ctrl_o.mdr_in = 1'b1; end
      LD_T9:   begin ctrl_o.mdr_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1; end
      ST_T7:   begin ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.write = 1'b1; end
      BR_T5:   begin ctrl_o.pc_out = 1'b1; ctrl_o.y_in = 1'b1; end
      BR_T7:   begin ctrl_o.zlow_out = 1'b1; ctrl_o.branch = 1'b1; ctrl_o.pc_in = conff_i; end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle CPU control unit: state register, next-state logic and the
// pending-stop latch; the control word comes from ctrl_decode.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int OPW = OP_W,
  parameter int STW = ST_W
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        CONFF,
  input  logic        stop,
  output logic        clear,
  output logic        Run,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        MD_read,
  output logic        IRin,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Csignout,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Zhighin,
  output logic        Zlowout,
  output logic        ADD,
  output logic        AND,
  output logic        OR,
  output logic        BRANCH,
  output logic        CONin,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        Out_Portin
);

  logic [STW-1:0] state_q;
  state_e         state, state_d, last_next;
  logic           stop_q, stop_d;
  logic [OPW-1:0] opcode;
  logic           unused_ir;
  ctrl_t          ctrl;

  assign opcode    = IR[31 -: OPW];
  assign unused_ir = ^IR[31-OPW:0];
  assign state     = state_e'(state_q);
  assign stop_d    = stop_q | stop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= CLR;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    last_next = (stop || stop_q) ? HALT : T0;
    state_d   = state;
    case (state)
      CLR: state_d = T0;
      T0:  state_d = T1;
      T1:  state_d = T2;
      T2:  state_d = T3;
      T3:  state_d = T4;
      T4: begin
        case (opcode)
          OP_ADD:  state_d = ADD_T5;
          OP_AND:  state_d = AND_T5;
          OP_OR:   state_d = OR_T5;
          OP_ADDI: state_d = ADDI_T5;
          OP_ANDI: state_d = ANDI_T5;
          OP_ORI:  state_d = ORI_T5;
          OP_LD:   state_d = LD_T5;
          OP_LDI:  state_d = LDI_T5;
          OP_ST:   state_d = ST_T5;
          OP_BR:   state_d = BR_T5;
          OP_HALT: state_d = HALT;
          default: state_d = last_next;
        endcase
      end
      ADD_T5, AND_T5, OR_T5, ADDI_T5, ANDI_T5, ORI_T5, LDI_T5: state_d = ALU_T6;
      ALU_T6, LD_T9, ST_T7, BR_T7: state_d = last_next;
      LD_T5: state_d = LD_T6;
      LD_T6: state_d = LD_T7;
      LD_T7: state_d = LD_T8;
      LD_T8: state_d = LD_T9;
      ST_T5: state_d = ST_T6;
      ST_T6: state_d = ST_T7;
      BR_T5: state_d = BR_T6;
      BR_T6: state_d = BR_T7;
      HALT:  state_d = HALT;
      default: state_d = CLR;
    endcase
  end

  ctrl_decode u_decode (
    .state_i  (state),
    .opcode_i (opcode),
    .conff_i  (CONFF),
    .ctrl_o   (ctrl)
  );

  // clear is gated so nothing is driven while reset is still held low.
  assign clear      = ctrl.clear & reset;
  assign Run        = ctrl.run;
  assign PCout      = ctrl.pc_out;
  assign PCin       = ctrl.pc_in;
  assign IncPC      = ctrl.inc_pc;
  assign MARin      = ctrl.mar_in;
  assign MDRin      = ctrl.mdr_in;
  assign MDRout     = ctrl.mdr_out;
  assign MD_read    = ctrl.md_read;
  assign IRin       = ctrl.ir_in;
  assign Read       = ctrl.read;
  assign Write      = ctrl.write;
  assign Gra        = ctrl.gra;
  assign Grb        = ctrl.grb;
  assign Grc        = ctrl.grc;
  assign Rin        = ctrl.r_in;
  assign Rout       = ctrl.r_out;
  assign BAout      = ctrl.ba_out;
  assign Csignout   = ctrl.csign_out;
  assign Yin        = ctrl.y_in;
  assign Zlowin     = ctrl.zlow_in;
  assign Zhighin    = ctrl.zhigh_in;
  assign Zlowout    = ctrl.zlow_out;
  assign ADD        = ctrl.alu_add;
  assign AND        = ctrl.alu_and;
  assign OR         = ctrl.alu_or;
  assign BRANCH     = ctrl.branch;
  assign CONin      = ctrl.con_in;
  assign HIout      = ctrl.hi_out;
  assign LOout      = ctrl.lo_out;
  assign InPortout  = ctrl.inport_out;
  assign Out_Portin = ctrl.outport_in;

endmodule
